// File: rtl/mte_pkg.sv
// Shared constants and types for the MTE output byte serializer.
package mte_pkg;
    localparam int N        = 256;
    localparam int BYTE_W   = 8;
    localparam int NBYTES   = N / BYTE_W;
    localparam int IDX_W    = $clog2(NBYTES);
    localparam int DROP_MAX = 255;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;
endpackage

// File: rtl/mte_blk_buf.sv
// Two-entry block store: an active entry being serialized plus one pending entry.
module mte_blk_buf
    import mte_pkg::*;
#(
    parameter int N = mte_pkg::N
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [N-1:0] data_i,
    input  logic         mode_i,
    output logic [N-1:0] act_data_o,
    output logic         act_mode_o,
    output logic [1:0]   cnt_o
);
    logic [N-1:0] act_data_q, act_data_d, pnd_data_q, pnd_data_d;
    logic         act_mode_q, act_mode_d, pnd_mode_q, pnd_mode_d;
    logic [1:0]   cnt_q, cnt_d;

    // The caller never pushes while full, so count stays within 0..2.
    always_comb begin
        act_data_d = act_data_q;
        act_mode_d = act_mode_q;
        pnd_data_d = pnd_data_q;
        pnd_mode_d = pnd_mode_q;
        cnt_d      = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
        if (pop_i) begin
            if (cnt_q == 2'd2) begin
                act_data_d = pnd_data_q;
                act_mode_d = pnd_mode_q;
            end else if (push_i) begin
                act_data_d = data_i;
                act_mode_d = mode_i;
            end
        end else if (push_i) begin
            if (cnt_q == 2'd0) begin
                act_data_d = data_i;
                act_mode_d = mode_i;
            end else begin
                pnd_data_d = data_i;
                pnd_mode_d = mode_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            act_data_q <= '0;
            act_mode_q <= 1'b0;
            pnd_data_q <= '0;
            pnd_mode_q <= 1'b0;
            cnt_q      <= 2'd0;
        end else begin
            act_data_q <= act_data_d;
            act_mode_q <= act_mode_d;
            pnd_data_q <= pnd_data_d;
            pnd_mode_q <= pnd_mode_d;
            cnt_q      <= cnt_d;
        end
    end

    assign act_data_o = act_data_q;
    assign act_mode_o = act_mode_q;
    assign cnt_o      = cnt_q;
endmodule

// File: rtl/mte_out_serializer.sv
// Captures MTE result blocks into a two-deep buffer and streams them LSB byte first
// over valid/ready; invalid-key and overflow loads are discarded and counted.
module mte_out_serializer
    import mte_pkg::*;
#(
    parameter int N = mte_pkg::N
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         blk_load_i,
    input  logic [N-1:0] blk_data_i,
    input  logic         blk_key_ok_i,
    input  logic         blk_mode_i,
    output logic         blk_busy_o,
    output logic [7:0]   byte_data_o,
    output logic         byte_valid_o,
    input  logic         byte_ready_i,
    output logic         byte_last_o,
    output logic         byte_mode_o,
    output logic         key_err_o,
    output logic         ovf_o,
    output logic [7:0]   drop_cnt_o
);
    localparam int NB = N / BYTE_W;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    if ((N % 8 != 0) || (N < 16)) begin : g_bad_n
        $error("mte_out_serializer: N must be a multiple of 8 and at least 16");
    end

    state_e       state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic         key_err_q, key_err_d, ovf_q, ovf_d;
    logic [7:0]   drop_q, drop_d;

    logic [N-1:0] act_data;
    logic         act_mode;
    logic [1:0]   cnt;
    logic         valid, hs, at_last, pop, accept;

    assign valid   = (state_q == SEND);
    assign hs      = valid && byte_ready_i;
    assign at_last = (idx_q == IW'(NB - 1));
    assign pop     = hs && at_last;
    // Busy is judged on the count at cycle start, so a same-cycle pop does not rescue a load.
    assign accept  = blk_load_i && blk_key_ok_i && (cnt != 2'd2);

    mte_blk_buf #(.N(N)) u_buf (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (accept),
        .pop_i      (pop),
        .data_i     (blk_data_i),
        .mode_i     (blk_mode_i),
        .act_data_o (act_data),
        .act_mode_o (act_mode),
        .cnt_o      (cnt)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        key_err_d = blk_load_i && !blk_key_ok_i;
        ovf_d     = blk_load_i && blk_key_ok_i && (cnt == 2'd2);
        drop_d    = drop_q;
        if ((key_err_d || ovf_d) && (drop_q != 8'(DROP_MAX))) drop_d = drop_q + 8'd1;
        if (hs) idx_d = at_last ? '0 : idx_q + IW'(1);
        case (state_q)
            IDLE: if (accept) state_d = SEND;
            SEND: if (pop && (cnt == 2'd1) && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            key_err_q <= 1'b0;
            ovf_q     <= 1'b0;
            drop_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            key_err_q <= key_err_d;
            ovf_q     <= ovf_d;
            drop_q    <= drop_d;
        end
    end

    assign byte_valid_o = valid;
    assign byte_data_o  = valid ? act_data[{idx_q, 3'b000} +: 8] : 8'd0;
    assign byte_last_o  = valid && at_last;
    assign byte_mode_o  = valid && act_mode;
    assign blk_busy_o   = (cnt == 2'd2);
    assign key_err_o    = key_err_q;
    assign ovf_o        = ovf_q;
    assign drop_cnt_o   = drop_q;
endmodule

// File: tb/tb_mte_out_serializer.sv
// Randomized bench for mte_out_serializer against a queue-of-blocks reference model.
module tb_mte_out_serializer;
    localparam int N  = 256;
    localparam int NB = N / 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         blk_load = 1'b0;
    logic [N-1:0] blk_data = '0;
    logic         blk_key_ok = 1'b0;
    logic         blk_mode = 1'b0;
    logic         blk_busy;
    logic [7:0]   byte_data;
    logic         byte_valid;
    logic         byte_ready = 1'b0;
    logic         byte_last;
    logic         byte_mode;
    logic         key_err;
    logic         ovf;
    logic [7:0]   drop_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: accepted blocks in arrival order, byte position in the head block.
    logic [N-1:0] qd[$];
    logic         qm[$];
    int           pos = 0;
    logic         e_kerr = 1'b0, e_ovf = 1'b0;
    logic [7:0]   e_drop = 8'd0;
    int           hs_cnt = 0;

    always #5 clk = ~clk;

    mte_out_serializer #(.N(N)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .blk_load_i   (blk_load),
        .blk_data_i   (blk_data),
        .blk_key_ok_i (blk_key_ok),
        .blk_mode_i   (blk_mode),
        .blk_busy_o   (blk_busy),
        .byte_data_o  (byte_data),
        .byte_valid_o (byte_valid),
        .byte_ready_i (byte_ready),
        .byte_last_o  (byte_last),
        .byte_mode_o  (byte_mode),
        .key_err_o    (key_err),
        .ovf_o        (ovf),
        .drop_cnt_o   (drop_cnt)
    );

    function automatic logic [N-1:0] rnd_blk();
        logic [N-1:0] r;
        for (int i = 0; i < N / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // One clock: drive at negedge, score every output against the model, advance the model at posedge.
    task automatic step(input bit ld, input logic [N-1:0] d, input bit k, input bit m, input bit rdy);
        logic [N-1:0] t;
        logic [7:0]   eb;
        logic         ev, el, em;
        int           cnt;
        blk_load = ld; blk_data = d; blk_key_ok = k; blk_mode = m; byte_ready = rdy;
        #1;
        cnt = qd.size();
        ev = (cnt > 0);
        eb = 8'd0; el = 1'b0; em = 1'b0;
        if (ev) begin
            t  = qd[0];
            eb = t[pos*8 +: 8];
            el = (pos == NB - 1);
            em = qm[0];
        end
        total++; if (byte_valid !== ev) begin bad++; $display("FAIL valid got=%b exp=%b t=%0t", byte_valid, ev, $time); end
        total++; if (byte_data !== eb) begin bad++; $display("FAIL data got=%h exp=%h t=%0t", byte_data, eb, $time); end
        total++; if (byte_last !== el) begin bad++; $display("FAIL last got=%b exp=%b t=%0t", byte_last, el, $time); end
        total++; if (byte_mode !== em) begin bad++; $display("FAIL mode got=%b exp=%b t=%0t", byte_mode, em, $time); end
        total++; if (blk_busy !== (cnt == 2)) begin bad++; $display("FAIL busy got=%b exp=%b t=%0t", blk_busy, (cnt == 2), $time); end
        total++; if (key_err !== e_kerr) begin bad++; $display("FAIL key_err got=%b exp=%b t=%0t", key_err, e_kerr, $time); end
        total++; if (ovf !== e_ovf) begin bad++; $display("FAIL ovf got=%b exp=%b t=%0t", ovf, e_ovf, $time); end
        total++; if (drop_cnt !== e_drop) begin bad++; $display("FAIL drop_cnt got=%0d exp=%0d t=%0t", drop_cnt, e_drop, $time); end
        @(posedge clk);
        e_kerr = 1'b0; e_ovf = 1'b0;
        if (rdy && cnt > 0) begin
            hs_cnt++;
            pos++;
            if (pos == NB) begin
                void'(qd.pop_front());
                void'(qm.pop_front());
                pos = 0;
            end
        end
        if (ld) begin
            if (!k) begin
                e_kerr = 1'b1;
                if (e_drop != 8'd255) e_drop++;
            end else if (cnt == 2) begin
                e_ovf = 1'b1;
                if (e_drop != 8'd255) e_drop++;
            end else begin
                qd.push_back(d);
                qm.push_back(m);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, rdy);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        blk_load = 1'b1; blk_key_ok = 1'b1; blk_data = rnd_blk(); byte_ready = 1'b1;
        @(posedge clk);
        qd.delete(); qm.delete(); pos = 0;
        e_kerr = 1'b0; e_ovf = 1'b0; e_drop = 8'd0;
        @(negedge clk);
        rst = 1'b0; blk_load = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({byte_valid, byte_data, byte_last, byte_mode, blk_busy, key_err, ovf, drop_cnt} !== '0) begin
            bad++; $display("FAIL reset_outputs got=%b exp=0", {byte_valid, byte_data, byte_last, byte_mode, blk_busy, key_err, ovf, drop_cnt});
        end
        idle(2, 1'b1);
    endtask

    task automatic test_single();
        logic [N-1:0] b;
        for (int i = 0; i < NB; i++) b[i*8 +: 8] = 8'(i);
        do_reset();
        step(1'b1, b, 1'b1, 1'b1, 1'b1);
        total++;
        if (byte_valid !== 1'b1 || byte_data !== 8'h00) begin
            bad++; $display("FAIL single_first got=%b/%h exp=1/00", byte_valid, byte_data);
        end
        idle(NB - 1, 1'b1);
        total++;
        if (byte_valid !== 1'b1 || byte_data !== 8'h1F || byte_last !== 1'b1) begin
            bad++; $display("FAIL single_last got=%b/%h/%b exp=1/1f/1", byte_valid, byte_data, byte_last);
        end
        idle(1, 1'b1);
        total++;
        if (byte_valid !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=0", byte_valid); end
    endtask

    task automatic test_backpressure();
        int c;
        do_reset();
        hs_cnt = 0;
        step(1'b1, rnd_blk(), 1'b1, 1'b0, 1'b0);
        c = 0;
        while (qd.size() > 0 && c < 400) begin
            step(1'b0, '0, 1'b0, 1'b0, (c % 4 == 0) || (c % 4 == 3));
            c++;
        end
        total++;
        if (hs_cnt != NB || byte_valid !== 1'b0) begin
            bad++; $display("FAIL backpressure_handshakes got=%0d/%b exp=%0d/0", hs_cnt, byte_valid, NB);
        end
    endtask

    task automatic test_invalid_key();
        do_reset();
        step(1'b1, rnd_blk(), 1'b0, 1'b1, 1'b1);
        total++;
        if (key_err !== 1'b1 || drop_cnt !== 8'd1 || byte_valid !== 1'b0) begin
            bad++; $display("FAIL invalid_key got=%b/%0d/%b exp=1/1/0", key_err, drop_cnt, byte_valid);
        end
        idle(2, 1'b1);
    endtask

    task automatic test_overflow();
        int run;
        do_reset();
        step(1'b1, rnd_blk(), 1'b1, 1'b1, 1'b0);
        step(1'b1, rnd_blk(), 1'b1, 1'b0, 1'b0);
        total++;
        if (blk_busy !== 1'b1) begin bad++; $display("FAIL ovf_busy got=%b exp=1", blk_busy); end
        step(1'b1, rnd_blk(), 1'b1, 1'b1, 1'b0);
        total++;
        if (ovf !== 1'b1 || drop_cnt !== 8'd1) begin
            bad++; $display("FAIL ovf_drop got=%b/%0d exp=1/1", ovf, drop_cnt);
        end
        run = 0;
        for (int i = 0; i < 2 * NB + 4; i++) begin
            if (byte_valid === 1'b1) run++;
            step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        end
        total++;
        if (run != 2 * NB) begin bad++; $display("FAIL ovf_no_bubble got=%0d exp=%0d", run, 2 * NB); end
    endtask

    task automatic test_final_edge();
        logic [N-1:0] dd;
        int g;
        do_reset();
        step(1'b1, rnd_blk(), 1'b1, 1'b0, 1'b0);
        step(1'b1, rnd_blk(), 1'b1, 1'b1, 1'b0);
        g = 0;
        while (pos != NB - 1 && g < 100) begin step(1'b0, '0, 1'b0, 1'b0, 1'b1); g++; end
        step(1'b1, rnd_blk(), 1'b1, 1'b0, 1'b1);
        total++;
        if (ovf !== 1'b1 || drop_cnt !== 8'd1) begin
            bad++; $display("FAIL edge_full got=%b/%0d exp=1/1", ovf, drop_cnt);
        end
        g = 0;
        while (pos != NB - 1 && g < 100) begin step(1'b0, '0, 1'b0, 1'b0, 1'b1); g++; end
        dd = rnd_blk();
        step(1'b1, dd, 1'b1, 1'b1, 1'b1);
        total++;
        if (byte_valid !== 1'b1 || byte_data !== dd[7:0] || ovf !== 1'b0) begin
            bad++; $display("FAIL edge_one got=%b/%h/%b exp=1/%h/0", byte_valid, byte_data, ovf, dd[7:0]);
        end
        idle(NB + 2, 1'b1);
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] dd;
        do_reset();
        step(1'b1, rnd_blk(), 1'b1, 1'b1, 1'b1);
        step(1'b1, rnd_blk(), 1'b0, 1'b0, 1'b1);
        idle(5, 1'b1);
        do_reset();
        total++;
        if ({byte_valid, byte_data, byte_last, byte_mode, blk_busy, key_err, ovf, drop_cnt} !== '0) begin
            bad++; $display("FAIL reset_mid got=%b exp=0", {byte_valid, byte_data, byte_last, byte_mode, blk_busy, key_err, ovf, drop_cnt});
        end
        dd = rnd_blk();
        step(1'b1, dd, 1'b1, 1'b0, 1'b1);
        total++;
        if (byte_data !== dd[7:0]) begin bad++; $display("FAIL reset_restart got=%h exp=%h", byte_data, dd[7:0]); end
        idle(NB + 1, 1'b1);
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 300; i++) step(1'b1, '0, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b1);
        total++;
        if (drop_cnt !== 8'd255) begin bad++; $display("FAIL saturate got=%0d exp=255", drop_cnt); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++)
            step(($urandom_range(0, 15) == 0), rnd_blk(), ($urandom_range(0, 5) != 0),
                 1'($urandom), ($urandom_range(0, 3) != 0));
        idle(2 * NB + 2, 1'b1);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_backpressure();
        test_invalid_key();
        test_overflow();
        test_final_edge();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
